// File: rtl/sd_cmd_sequencer_pkg.sv
// Shared constants for the SD CMD-line sequencer: response codes, FSM encodings
// and the serial CRC7 step used by both the transmit and receive checkers.
package sd_cmd_sequencer_pkg;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_136  = 2'b01;
  localparam logic [1:0] RESP_48   = 2'b10;
  localparam logic [1:0] RESP_48B  = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SEND  = 3'd2;
  localparam logic [2:0] ST_NCR   = 3'd3;
  localparam logic [2:0] ST_RECV  = 3'd4;
  localparam logic [2:0] ST_CHECK = 3'd5;
  localparam logic [2:0] ST_NCC   = 3'd6;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  // One bit of x^7+x^3+1, MSB-first, as used on the SD CMD line.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// Host-register, status and CMD-pad signals of the sequencer bundled as one interface.
interface sd_cmd_sequencer_if;

  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [1:0]  resp_type;
  logic        data_present;
  logic        cmd_in;
  logic        cmd_out;
  logic        cmd_oe;
  logic        busy;
  logic        done;
  logic [5:0]  resp_index;
  logic [31:0] resp_arg;
  logic        err_timeout;
  logic        err_crc;
  logic        err_frame;
  logic        err_index;
  logic        err_type;
  logic        data_start;

  modport master (
    output start, cmd_index, cmd_arg, resp_type, data_present, cmd_in,
    input  cmd_out, cmd_oe, busy, done, resp_index, resp_arg,
           err_timeout, err_crc, err_frame, err_index, err_type, data_start
  );

  modport slave (
    input  start, cmd_index, cmd_arg, resp_type, data_present, cmd_in,
    output cmd_out, cmd_oe, busy, done, resp_index, resp_arg,
           err_timeout, err_crc, err_frame, err_index, err_type, data_start
  );

endinterface

// File: rtl/sd_cmd_sequencer_crc7.sv
// Serial CRC7 accumulator; clr has priority over en. Datapath only, so no reset.
module sd_crc7
  import sd_cmd_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr)
      crc_d = 7'h00;
    else if (en)
      crc_d = crc7_step(crc_q, bit_in);
  end

  always_ff @(posedge clk) begin
    crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD CMD-line transaction sequencer: sends a 48-bit command with CRC7, hunts for and
// receives the 48-bit response, checks it, then idles NCC cycles before pulsing done.
module sd_cmd_sequencer
  import sd_cmd_sequencer_pkg::*;
#(
  parameter int unsigned NCR_MIN = 2,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned NCC_MIN = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sd_cmd_sequencer_if.slave  bus
);

  localparam int TMO_W = $clog2(NCR_MIN + TIMEOUT + NCC_MIN + 1);
  localparam logic [TMO_W-1:0] HUNT_FIRST = TMO_W'(NCR_MIN);
  localparam logic [TMO_W-1:0] HUNT_LAST  = TMO_W'(NCR_MIN + TIMEOUT - 1);
  localparam logic [TMO_W-1:0] NCC_LAST   = TMO_W'(NCC_MIN);

  // Control state (async reset)
  logic [2:0]       state_q, state_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [5:0]       resp_index_q, resp_index_d;
  logic [31:0]      resp_arg_q, resp_arg_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_crc_q, err_crc_d;
  logic             err_frame_q, err_frame_d;
  logic             err_index_q, err_index_d;
  logic             err_type_q, err_type_d;

  // Datapath state (no reset)
  logic [47:0]      tx_sr_q, tx_sr_d;
  logic [47:0]      rx_sr_q, rx_sr_d;
  logic [5:0]       idx_q, idx_d;
  logic [31:0]      arg_q, arg_d;
  logic [1:0]       rtype_q, rtype_d;
  logic             dpres_q, dpres_d;

  logic             tx_crc_clr, tx_crc_en;
  logic             rx_crc_clr, rx_crc_en;
  logic [6:0]       tx_crc, rx_crc;
  logic [2:0]       crc_sel;
  logic             cmd_out;
  logic             done;
  logic             any_err;

  sd_crc7 u_tx_crc (
    .clk    (clk),
    .clr    (tx_crc_clr),
    .en     (tx_crc_en),
    .bit_in (tx_sr_q[47]),
    .crc    (tx_crc)
  );

  sd_crc7 u_rx_crc (
    .clk    (clk),
    .clr    (rx_crc_clr),
    .en     (rx_crc_en),
    .bit_in (bus.cmd_in),
    .crc    (rx_crc)
  );

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    resp_index_d  = resp_index_q;
    resp_arg_d    = resp_arg_q;
    err_timeout_d = err_timeout_q;
    err_crc_d     = err_crc_q;
    err_frame_d   = err_frame_q;
    err_index_d   = err_index_q;
    err_type_d    = err_type_q;
    tx_sr_d       = tx_sr_q;
    rx_sr_d       = rx_sr_q;
    idx_d         = idx_q;
    arg_d         = arg_q;
    rtype_d       = rtype_q;
    dpres_d       = dpres_q;
    tx_crc_clr    = 1'b0;
    tx_crc_en     = 1'b0;
    rx_crc_clr    = 1'b0;
    rx_crc_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          idx_d         = bus.cmd_index;
          arg_d         = bus.cmd_arg;
          rtype_d       = bus.resp_type;
          dpres_d       = bus.data_present;
          err_timeout_d = 1'b0;
          err_crc_d     = 1'b0;
          err_frame_d   = 1'b0;
          err_index_d   = 1'b0;
          err_type_d    = 1'b0;
          state_d       = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // CRC field left zero in the shift register; it is muxed in from the TX CRC
        tx_sr_d    = {2'b01, idx_q, arg_q, 8'h01};
        tx_crc_clr = 1'b1;
        rx_crc_clr = 1'b1;
        bit_cnt_d  = 6'd47;
        tmo_cnt_d  = '0;
        if (rtype_q == RESP_136) begin
          err_type_d = 1'b1;
          state_d    = ST_NCC;
        end else begin
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_sr_d   = {tx_sr_q[46:0], 1'b0};
        tx_crc_en = (bit_cnt_q >= 6'd8);
        bit_cnt_d = bit_cnt_q - 6'd1;
        if (bit_cnt_q == 6'd0)
          state_d = (rtype_q == RESP_NONE) ? ST_NCC : ST_NCR;
      end
      ST_NCR: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (tmo_cnt_q >= HUNT_FIRST) begin
          if (!bus.cmd_in) begin
            rx_sr_d   = 48'h0;
            rx_crc_en = 1'b1;
            bit_cnt_d = 6'd46;
            state_d   = ST_RECV;
          end else if (tmo_cnt_q == HUNT_LAST) begin
            err_timeout_d = 1'b1;
            tmo_cnt_d     = '0;
            state_d       = ST_NCC;
          end
        end
      end
      ST_RECV: begin
        rx_sr_d   = {rx_sr_q[46:0], bus.cmd_in};
        rx_crc_en = (bit_cnt_q >= 6'd8);
        bit_cnt_d = bit_cnt_q - 6'd1;
        if (bit_cnt_q == 6'd0)
          state_d = ST_CHECK;
      end
      ST_CHECK: begin
        resp_index_d = rx_sr_q[45:40];
        resp_arg_d   = rx_sr_q[39:8];
        err_crc_d    = (rx_sr_q[7:1] != rx_crc);
        err_frame_d  = rx_sr_q[47] | rx_sr_q[46] | ~rx_sr_q[0];
        // RESP_48B shares the 48-bit path; its busy phase belongs to the DAT side
        err_index_d  = (rtype_q == RESP_48) && (rx_sr_q[45:40] != idx_q);
        tmo_cnt_d    = '0;
        state_d      = ST_NCC;
      end
      ST_NCC: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (tmo_cnt_q == NCC_LAST)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    crc_sel = bit_cnt_q[2:0] - 3'd1;
    cmd_out = 1'b1;
    if (state_q == ST_SEND) begin
      if (bit_cnt_q >= 6'd8)
        cmd_out = tx_sr_q[47];
      else if (bit_cnt_q != 6'd0)
        cmd_out = tx_crc[crc_sel];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      resp_index_q  <= '0;
      resp_arg_q    <= '0;
      err_timeout_q <= 1'b0;
      err_crc_q     <= 1'b0;
      err_frame_q   <= 1'b0;
      err_index_q   <= 1'b0;
      err_type_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      resp_index_q  <= resp_index_d;
      resp_arg_q    <= resp_arg_d;
      err_timeout_q <= err_timeout_d;
      err_crc_q     <= err_crc_d;
      err_frame_q   <= err_frame_d;
      err_index_q   <= err_index_d;
      err_type_q    <= err_type_d;
    end
  end

  always_ff @(posedge clk) begin
    tx_sr_q <= tx_sr_d;
    rx_sr_q <= rx_sr_d;
    idx_q   <= idx_d;
    arg_q   <= arg_d;
    rtype_q <= rtype_d;
    dpres_q <= dpres_d;
  end

  assign done    = (state_q == ST_NCC) && (tmo_cnt_q == NCC_LAST);
  assign any_err = err_timeout_q | err_crc_q | err_frame_q | err_index_q | err_type_q;

  assign bus.cmd_out     = cmd_out;
  assign bus.cmd_oe      = (state_q == ST_SEND);
  assign bus.busy        = (state_q != ST_IDLE) && !done;
  assign bus.done        = done;
  assign bus.resp_index  = resp_index_q;
  assign bus.resp_arg    = resp_arg_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_crc     = err_crc_q;
  assign bus.err_frame   = err_frame_q;
  assign bus.err_index   = err_index_q;
  assign bus.err_type    = err_type_q;
  assign bus.data_start  = done & dpres_q & ~any_err;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer: a simple card model answers on cmd_in while
// the command stream, latency, response fields and error flags are checked.
module tb_sd_cmd_sequencer;
  import sd_cmd_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sd_cmd_sequencer_if bus ();

  sd_cmd_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  logic [47:0] tx_got;
  int          oe_cycles;
  int          done_k;
  logic        ds_at_done;
  logic        busy_k1;
  int          done_seen;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] resp_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    logic [6:0]  c;
    logic        fb;
    h = {2'b00, idx, arg};
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = h[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return {h, c, 1'b1};
  endfunction

  function automatic logic [4:0] errs();
    return {bus.err_timeout, bus.err_crc, bus.err_frame, bus.err_index, bus.err_type};
  endfunction

  // One transaction; cycle k counts negedges after the cycle start is high (k=0).
  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input logic dp, input bit respond, input int delay,
                         input logic [47:0] rframe, input bit restart);
    int drop_k;
    bus.cmd_index    = idx;
    bus.cmd_arg      = arg;
    bus.resp_type    = rt;
    bus.data_present = dp;
    @(negedge clk);
    bus.start  = 1'b1;
    tx_got     = '0;
    oe_cycles  = 0;
    done_k     = -1;
    drop_k     = -1;
    ds_at_done = 1'b0;
    busy_k1    = 1'b0;
    for (int k = 1; k <= 400 && done_k < 0; k++) begin
      @(negedge clk);
      bus.start = restart && (k == 10);
      if (restart && k == 10) bus.cmd_index = 6'd63;
      if (k == 1) busy_k1 = bus.busy;
      if (bus.cmd_oe) begin
        tx_got = {tx_got[46:0], bus.cmd_out};
        oe_cycles++;
      end else if (oe_cycles > 0 && drop_k < 0) begin
        drop_k = k;
      end
      if (respond && drop_k >= 0 && k >= drop_k + delay && k < drop_k + delay + 48)
        bus.cmd_in = rframe[47 - (k - drop_k - delay)];
      else
        bus.cmd_in = 1'b1;
      if (bus.done) begin
        done_k     = k;
        ds_at_done = bus.data_start;
      end
    end
    bus.start  = 1'b0;
    bus.cmd_in = 1'b1;
    if (done_k < 0) chk("done_timeout", 48'd0, 48'd1);
  endtask

  initial begin
    logic [47:0] good17;
    bus.start        = 1'b0;
    bus.cmd_index    = '0;
    bus.cmd_arg      = '0;
    bus.resp_type    = RESP_NONE;
    bus.data_present = 1'b0;
    bus.cmd_in       = 1'b1;
    good17 = resp_frame(6'd17, 32'h900);

    repeat (3) @(negedge clk);
    chk("reset_ctrl", {43'd0, bus.cmd_oe, bus.cmd_out, bus.busy, bus.done, bus.data_start}, {43'd0, 5'b01000});
    chk("reset_resp", {10'd0, bus.resp_index, bus.resp_arg}, 48'd0);
    chk("reset_err", {43'd0, errs()}, 48'd0);
    rst_n = 1'b1;

    // CMD0, no response
    run_txn(6'd0, 32'h0, RESP_NONE, 1'b0, 1'b0, 0, 48'd0, 1'b0);
    chk("cmd0_tx", tx_got, 48'h40_0000_0000_95);
    chk("cmd0_oe_len", 48'(oe_cycles), 48'd48);
    chk("cmd0_done_cyc", 48'(done_k), 48'd58);
    chk("cmd0_busy", {47'd0, busy_k1}, 48'd1);
    chk("cmd0_err", {43'd0, errs()}, 48'd0);
    @(negedge clk);
    chk("cmd0_after", {46'd0, bus.done, bus.busy}, 48'd0);

    // CMD17, clean response after 5 cycles
    run_txn(6'd17, 32'h0, RESP_48, 1'b0, 1'b1, 5, good17, 1'b0);
    chk("cmd17_tx", tx_got, 48'h51_0000_0000_55);
    chk("cmd17_done_cyc", 48'(done_k), 48'd112);
    chk("cmd17_idx", {42'd0, bus.resp_index}, 48'd17);
    chk("cmd17_arg", {16'd0, bus.resp_arg}, 48'h900);
    chk("cmd17_err", {43'd0, errs()}, 48'd0);

    // CMD8, card silent
    run_txn(6'd8, 32'h1AA, RESP_48, 1'b0, 1'b0, 0, 48'd0, 1'b0);
    chk("cmd8_tx", tx_got, 48'h48_0000_01AA_87);
    chk("cmd8_done_cyc", 48'(done_k), 48'd124);
    chk("cmd8_err", {43'd0, errs()}, 48'h10);
    chk("cmd8_ds", {47'd0, ds_at_done}, 48'd0);

    // Corrupted responses
    run_txn(6'd17, 32'h0, RESP_48, 1'b0, 1'b1, 5, good17 ^ 48'h2, 1'b0);
    chk("crc_err", {43'd0, errs()}, 48'h08);
    run_txn(6'd17, 32'h0, RESP_48, 1'b0, 1'b1, 5, resp_frame(6'd18, 32'h900), 1'b0);
    chk("idx_err", {43'd0, errs()}, 48'h02);
    chk("idx_val", {42'd0, bus.resp_index}, 48'd18);
    run_txn(6'd17, 32'h0, RESP_48, 1'b0, 1'b1, 5, good17 & ~48'h1, 1'b0);
    chk("end_err", {43'd0, errs()}, 48'h04);

    // Data command with a stray start during SEND
    run_txn(6'd17, 32'h0, RESP_48, 1'b1, 1'b1, 5, good17, 1'b1);
    chk("dat_tx", tx_got, 48'h51_0000_0000_55);
    chk("dat_done_cyc", 48'(done_k), 48'd112);
    chk("dat_ds", {47'd0, ds_at_done}, 48'd1);
    chk("dat_err", {43'd0, errs()}, 48'd0);

    // Unsupported 136-bit response
    run_txn(6'd2, 32'h0, RESP_136, 1'b1, 1'b0, 0, 48'd0, 1'b0);
    chk("r2_done_cyc", 48'(done_k), 48'd10);
    chk("r2_oe", 48'(oe_cycles), 48'd0);
    chk("r2_err", {43'd0, errs()}, 48'h01);
    chk("r2_ds", {47'd0, ds_at_done}, 48'd0);

    // Reset while bit 20 is on the line
    bus.cmd_index = 6'd0;
    bus.cmd_arg   = 32'h0;
    bus.resp_type = RESP_NONE;
    bus.data_present = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (28) @(negedge clk);
    chk("pre_rst_oe", {47'd0, bus.cmd_oe}, 48'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ctrl", {45'd0, bus.cmd_oe, bus.cmd_out, bus.busy}, {45'd0, 3'b010});
    chk("rst_resp", {10'd0, bus.resp_index, bus.resp_arg}, 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.done || bus.cmd_oe || bus.busy) done_seen++;
    end
    chk("rst_no_done", 48'(done_seen), 48'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
